// File: rtl/sleep_units.sv
// Purpose: blocking sleep of __p_count units (cycles/us/ms/s) behind a __start/__valid/__idle call handshake.
// Latency: __valid in cycle S+count*div (S = start cycle); count==0 completes in S+1.
// Backpressure: __start accepted only while __idle=1; no output backpressure (__valid is a one-cycle strobe).
//
// Ports:
//   __clk, __reset    single clock, synchronous active-high reset
//   __p_count/__p_unit call arguments, sampled only on an accepted start
//   __start           call request, honoured only while __idle=1
//   __cancel          abort request (exists only when SLEEP_UNITS_CANCEL_EN is defined)
//   __valid           one-cycle completion strobe
//   __idle            ready for a new call
//   __r               whole units elapsed; held until the next accepted start
// Optional feature macro: SLEEP_UNITS_CANCEL_EN (adds __cancel and early abort).
module sleep_units #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned COUNT_W  = 32
) (
    input  logic               __clk,
    input  logic               __reset,
    input  logic [COUNT_W-1:0] __p_count,
    input  logic [1:0]         __p_unit,
    input  logic               __start,
`ifdef SLEEP_UNITS_CANCEL_EN
    input  logic               __cancel,
`endif
    output logic               __valid,
    output logic               __idle,
    output logic [COUNT_W-1:0] __r
);

    localparam int unsigned DIV_US_RAW = CLK_FREQ / 1000000;
    localparam logic [31:0] DIV_US = (DIV_US_RAW < 1) ? 32'd1 : 32'(DIV_US_RAW);
    localparam logic [31:0] DIV_MS = 32'(CLK_FREQ / 1000);
    localparam logic [31:0] DIV_S  = 32'(CLK_FREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        div;
    logic [31:0]        pre;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] elapsed;

    logic [31:0]        div_sel;
    logic [COUNT_W-1:0] elapsed_nxt;
    logic               unit_tick;
    logic               cancel_req;

    always_comb begin
        div_sel = 32'd1;
        case (__p_unit)
            2'd0:    div_sel = 32'd1;
            2'd1:    div_sel = DIV_US;
            2'd2:    div_sel = DIV_MS;
            default: div_sel = DIV_S;
        endcase
    end

    assign elapsed_nxt = elapsed + COUNT_W'(1);
    assign unit_tick   = (pre == div - 32'd1);

`ifdef SLEEP_UNITS_CANCEL_EN
    assign cancel_req = __cancel;
`else
    assign cancel_req = 1'b0;
`endif

    // The start edge itself counts as the first clock of the wait, so the
    // counters leave IDLE already one tick in; this is what places __valid in
    // cycle S+count*div rather than one cycle later.
    always_ff @(posedge __clk) begin
        if (__reset) begin
            state   <= IDLE;
            __valid <= 1'b0;
            __idle  <= 1'b1;
            __r     <= '0;
            div     <= 32'd1;
            pre     <= '0;
            count   <= '0;
            elapsed <= '0;
        end else begin
            case (state)
                IDLE: begin
                    __valid <= 1'b0;
                    if (__start) begin
                        count  <= __p_count;
                        div    <= div_sel;
                        __idle <= 1'b0;
                        if (__p_count == '0) begin
                            pre     <= '0;
                            elapsed <= '0;
                            __valid <= 1'b1;
                            __r     <= '0;
                            state   <= DONE;
                        end else if (div_sel == 32'd1) begin
                            // One unit per clock: the start edge completes unit 1.
                            pre     <= '0;
                            elapsed <= COUNT_W'(1);
                            if (__p_count == COUNT_W'(1)) begin
                                __valid <= 1'b1;
                                __r     <= __p_count;
                                state   <= DONE;
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            pre     <= 32'd1;
                            elapsed <= '0;
                            state   <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (unit_tick) begin
                        pre     <= '0;
                        elapsed <= elapsed_nxt;
                        // Final tick beats a simultaneous cancel.
                        if (elapsed_nxt == count) begin
                            __valid <= 1'b1;
                            __r     <= count;
                            state   <= DONE;
                        end else if (cancel_req) begin
                            __valid <= 1'b1;
                            __r     <= elapsed;
                            state   <= DONE;
                        end
                    end else begin
                        pre <= pre + 32'd1;
                        // Partial unit in progress is dropped on cancel.
                        if (cancel_req) begin
                            __valid <= 1'b1;
                            __r     <= elapsed;
                            state   <= DONE;
                        end
                    end
                end

                DONE: begin
                    __valid <= 1'b0;
                    __idle  <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    __valid <= 1'b0;
                    __idle  <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sleep_units.sv
// Purpose: randomized self-checking bench for sleep_units against a latency/return model.
// Latency: model expects __valid at S+max(count*div,1), or S+k+1 on a cancel sampled in cycle S+k.
// Backpressure: bench only starts calls when __idle is expected high.
module tb_sleep_units;

    localparam int unsigned CLK_FREQ = 2000000;
    localparam int unsigned COUNT_W  = 32;
`ifdef SLEEP_UNITS_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [COUNT_W-1:0] p_count;
    logic [1:0]         p_unit;
    logic               start;
    logic               cancel;
    logic               valid;
    logic               idle;
    logic [COUNT_W-1:0] r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sleep_units #(
        .CLK_FREQ (CLK_FREQ),
        .COUNT_W  (COUNT_W)
    ) dut (
        .__clk     (clk),
        .__reset   (rst),
        .__p_count (p_count),
        .__p_unit  (p_unit),
        .__start   (start),
`ifdef SLEEP_UNITS_CANCEL_EN
        .__cancel  (cancel),
`endif
        .__valid   (valid),
        .__idle    (idle),
        .__r       (r)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles per unit, straight from the clock frequency.
    function automatic longint unit_div(input int u);
        longint d;
        case (u)
            0:       d = 1;
            1:       d = (CLK_FREQ / 1000000 < 1) ? 1 : CLK_FREQ / 1000000;
            2:       d = CLK_FREQ / 1000;
            default: d = CLK_FREQ;
        endcase
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Starts a call in the current cycle (S) and follows it through the
    // cycle after __valid. cancel_at = k asserts __cancel in cycle S+k; -1 = none.
    task automatic run_call(input longint cnt, input int u, input longint cancel_at);
        longint d, n, exp_lat, exp_r, lat, rv;
        int     viol;
        bit     seen;
        d       = unit_div(u);
        n       = (cnt == 0) ? 1 : cnt * d;
        exp_lat = n;
        exp_r   = cnt;
        if (CANCEL_EN && cancel_at >= 1 && cancel_at + 1 < n) begin
            exp_lat = cancel_at + 1;
            exp_r   = cancel_at / d;
        end

        check("idle_before_start", idle, 1);
        p_count = COUNT_W'(cnt);
        p_unit  = 2'(u);
        start   = 1'b1;
        cancel  = (cancel_at == 0);
        seen = 0;
        lat  = -1;
        rv   = -1;
        viol = 0;
        for (longint i = 1; i <= n + 3 && !seen; i++) begin
            step();
            if (valid) begin
                seen = 1;
                lat  = i;
                rv   = r;
            end
            if (idle) viol++;
            // Argument and start noise after acceptance must be ignored.
            p_count = $urandom;
            p_unit  = 2'($urandom_range(0, 3));
            start   = 1'($urandom_range(0, 1));
            cancel  = (i == cancel_at);
        end
        check("valid_latency", lat, exp_lat);
        check("return_value", rv, exp_r);
        check("idle_low_while_busy", viol, 0);
        if (seen) begin
            step();
            start  = 1'b0;
            cancel = 1'b0;
            check("valid_one_cycle", valid, 0);
            check("idle_after_done", idle, 1);
            check("r_held_after_done", r, exp_r);
        end else begin
            do_reset();
        end
    endtask

    initial begin
        longint cnt, n, cat;
        int     u, vcount;
        rst     = 1'b1;
        p_count = '0;
        p_unit  = '0;
        start   = 1'b0;
        cancel  = 1'b0;
        do_reset();
        check("reset_valid", valid, 0);
        check("reset_idle", idle, 1);
        check("reset_r", r, 0);

        // Directed cases; calls run back-to-back (next start in cycle after __valid).
        run_call(5, 0, -1);
        run_call(0, 3, -1);
        run_call(3, 1, -1);
        run_call(1, 0, -1);
        run_call(1, 2, -1);
        if (CANCEL_EN) begin
            run_call(10, 1, 5);
            run_call(10, 1, 19);
            run_call(4, 0, 0);
            run_call(6, 0, 3);
        end

        // Reset in the middle of a ms wait: silent abort, outputs back to reset values.
        p_count = 2;
        p_unit  = 2;
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (999) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrun_reset_idle", idle, 1);
        check("midrun_reset_r", r, 0);
        vcount = 0;
        repeat (4200) begin
            step();
            if (valid) vcount++;
        end
        check("midrun_reset_no_valid", vcount, 0);

        // Randomized calls.
        for (int t = 0; t < 60; t++) begin
            u = $urandom_range(0, 3);
            case (u)
                0:       cnt = $urandom_range(0, 40);
                1:       cnt = $urandom_range(0, 25);
                2:       cnt = $urandom_range(0, 1);
                default: cnt = 0;
            endcase
            n   = (cnt == 0) ? 1 : cnt * unit_div(u);
            cat = -1;
            if (CANCEL_EN && $urandom_range(0, 1) == 1)
                cat = $urandom_range(0, 32'(n + 1));
            run_call(cnt, u, cat);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) step();
                check("gap_valid_low", valid, 0);
                check("gap_idle_high", idle, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
